// File: rtl/dec_rr_arbiter4.sv
// -----------------------------------------------------------------------------
// dec_rr_arbiter4
//
// Round-robin arbiter that shares one decoder-style select bus between four
// requesters. Each grant is presented as a registered 2-bit index (W) with an
// enable (En) plus the decoded one-hot selects y0..y3. A grant lasts while its
// request stays high, up to MAX_HOLD cycles. Every release, voluntary or
// forced, is followed by one dead cycle so two selects are never high on
// consecutive cycles.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   req      request vector, req[i] belongs to requester i
//   W        granted index; holds the last grant while En is low
//   En       grant valid
//   y0..y3   decoded grant selects, y[i] = En && (W == i)
//   timeout  one-cycle pulse when a grant is force-released at MAX_HOLD
//
// Every output comes straight from a flop; req only reaches the outputs
// through the state registers.
// -----------------------------------------------------------------------------
module dec_rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [1:0] W,
    output logic       En,
    output logic       y0,
    output logic       y1,
    output logic       y2,
    output logic       y3,
    output logic       timeout
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [3:0]       y_reg;
    logic [1:0]       pick_idx;
    logic             pick_valid;

    // Rotating priority scan. The search starts just after the most recent
    // winner, so that winner is the last one considered. The 2-bit index
    // arithmetic wraps naturally, and k == 4 lands back on ptr itself.
    always_comb begin
        pick_idx   = ptr;
        pick_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!pick_valid && req[ptr + 2'(k)]) begin
                pick_idx   = ptr + 2'(k);
                pick_valid = 1'b1;
            end
        end
    end

    // Arbitration state machine. New grants are only issued from IDLE or GAP,
    // so requests that arrive while a grant is active wait for the gap cycle.
    // While GRANT is active, a dropped request takes precedence over the hold
    // limit, so timeout only fires when the owner is still asking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            W        <= 2'd0;
            En       <= 1'b0;
            y_reg    <= 4'b0000;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            ptr      <= 2'd3;
        end else begin
            case (state)
                IDLE, GAP: begin
                    timeout <= 1'b0;
                    if (pick_valid) begin
                        W        <= pick_idx;
                        En       <= 1'b1;
                        y_reg    <= 4'b0001 << pick_idx;
                        ptr      <= pick_idx;
                        hold_cnt <= CNT_W'(1);
                        state    <= GRANT;
                    end else begin
                        En    <= 1'b0;
                        y_reg <= 4'b0000;
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (!req[W]) begin
                        En      <= 1'b0;
                        y_reg   <= 4'b0000;
                        timeout <= 1'b0;
                        state   <= GAP;
                    end else if (hold_cnt == CNT_W'(MAX_HOLD)) begin
                        En      <= 1'b0;
                        y_reg   <= 4'b0000;
                        timeout <= 1'b1;
                        state   <= GAP;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                        timeout  <= 1'b0;
                    end
                end
                default: begin
                    En      <= 1'b0;
                    y_reg   <= 4'b0000;
                    timeout <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign y0 = y_reg[0];
    assign y1 = y_reg[1];
    assign y2 = y_reg[2];
    assign y3 = y_reg[3];

    // Bus-safety invariants of the decoded select interface.
    a_onehot_y : assert property (@(posedge clk) disable iff (rst)
        $onehot0({y3, y2, y1, y0}));
    a_y_needs_en : assert property (@(posedge clk) disable iff (rst)
        !En |-> ({y3, y2, y1, y0} == 4'b0000));
    a_timeout_pulse : assert property (@(posedge clk) disable iff (rst)
        timeout |=> !timeout);

endmodule

// File: tb/tb_dec_rr_arbiter4.sv
// -----------------------------------------------------------------------------
// tb_dec_rr_arbiter4
//
// Self-checking bench for dec_rr_arbiter4 (MAX_HOLD = 8). A behavioural
// reference model predicts the outputs for every applied cycle. The
// prediction is queued when the stimulus is driven, then popped and compared
// against the DUT one time unit after the clock edge that produces it. A few
// hand-derived expectations, such as grant order and timeout count, are
// checked on top of that.
// -----------------------------------------------------------------------------
module tb_dec_rr_arbiter4;

    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] W;
    logic       En;
    logic       y0, y1, y2, y3;
    logic       timeout;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [1:0] w;
        logic       en;
        logic [3:0] y;
        logic       to;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    int         m_state;   // 0 idle, 1 grant, 2 gap
    logic [1:0] m_w;
    logic       m_en;
    logic       m_to;
    int         m_ptr;
    int         m_len;

    // Observation helpers for the hand-checked scenarios
    logic       recording;
    logic       prev_en;
    int         grant_order[$];
    int         timeout_count;

    dec_rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .W       (W),
        .En      (En),
        .y0      (y0),
        .y1      (y1),
        .y2      (y2),
        .y3      (y3),
        .timeout (timeout)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if the values differ
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advances the reference model by one clock edge
    task automatic modelStep(input logic [3:0] r, input logic rs);
        int idx;
        bit found;
        if (rs) begin
            m_state = 0; m_w = 2'd0; m_en = 1'b0; m_to = 1'b0;
            m_ptr = 3; m_len = 0;
        end else if (m_state == 1) begin
            if (r[m_w] == 1'b0) begin
                m_en = 1'b0; m_to = 1'b0; m_state = 2;
            end else if (m_len >= MAX_HOLD) begin
                m_en = 1'b0; m_to = 1'b1; m_state = 2;
            end else begin
                m_len = m_len + 1; m_to = 1'b0;
            end
        end else begin
            m_to = 1'b0;
            found = 1'b0;
            for (int j = 1; j <= 4; j++) begin
                idx = (m_ptr + j) % 4;
                if (!found && r[idx]) begin
                    found = 1'b1;
                    m_w = idx[1:0];
                    m_ptr = idx;
                end
            end
            if (found) begin
                m_en = 1'b1; m_len = 1; m_state = 1;
            end else begin
                m_en = 1'b0; m_state = 0;
            end
        end
    endtask

    // Drives one cycle of stimulus, queues the prediction, then compares the
    // DUT against the oldest queued prediction after the edge
    task automatic applyStimulus(input logic [3:0] r, input logic rs);
        exp_t e;
        exp_t p;
        req = r;
        rst = rs;
        modelStep(r, rs);
        e.w  = m_w;
        e.en = m_en;
        e.y  = m_en ? (4'b0001 << m_w) : 4'b0000;
        e.to = m_to;
        sb.push_back(e);
        @(posedge clk);
        #1;
        p = sb.pop_front();
        checkOutput("W",       32'(W),                  32'(p.w));
        checkOutput("En",      32'(En),                 32'(p.en));
        checkOutput("y",       32'({y3, y2, y1, y0}),   32'(p.y));
        checkOutput("timeout", 32'(timeout),            32'(p.to));
        if (recording) begin
            if (En && !prev_en) grant_order.push_back(int'(W));
            if (timeout) timeout_count++;
        end
        prev_en = En;
    endtask

    initial begin
        int expected_order[5];
        expected_order = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        req = 4'b0000;
        recording = 1'b0;
        prev_en = 1'b0;
        timeout_count = 0;
        m_state = 0; m_w = 0; m_en = 0; m_to = 0; m_ptr = 3; m_len = 0;
        @(posedge clk);
        #1;

        // Reset state
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b1);

        // Single requester 0, released after three cycles
        repeat (3) applyStimulus(4'b0001, 1'b0);
        repeat (2) applyStimulus(4'b0000, 1'b0);

        // All requesting: grants rotate 0,1,2,3,0, each cut off by timeout
        applyStimulus(4'b0000, 1'b1);
        recording = 1'b1;
        repeat (44) applyStimulus(4'b1111, 1'b0);
        recording = 1'b0;
        checkOutput("grant_count", 32'(grant_order.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_order.size())
                checkOutput("grant_order", 32'(grant_order[i]), 32'(expected_order[i]));
        end
        checkOutput("timeout_count", 32'(timeout_count), 32'd4);

        // 0101: grant 0, brief drop of req[0], next grant must go to 2
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0101, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0101, 1'b0);
        checkOutput("after_drop_W", 32'(W), 32'd2);
        repeat (3) applyStimulus(4'b0101, 1'b0);
        repeat (2) applyStimulus(4'b0000, 1'b0);

        // Lone requester 2 held: timeout, one gap, regranted
        repeat (20) applyStimulus(4'b0100, 1'b0);

        // Reset in the middle of a grant of 2, then 1001 starts at 0
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        repeat (3) applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("mid_reset_En", 32'(En), 32'd0);
        applyStimulus(4'b1001, 1'b0);
        checkOutput("first_after_reset", 32'(W), 32'd0);
        repeat (12) applyStimulus(4'b1001, 1'b0);

        // Single-cycle pulse on requester 1
        repeat (2) applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0010, 1'b0);
        repeat (3) applyStimulus(4'b0000, 1'b0);

        // Random traffic
        for (int i = 0; i < 80; i++)
            applyStimulus(4'($urandom_range(0, 15)), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dec_rr_arbiter4.md
Name: dec_rr_arbiter4

Overview:
- Round-robin arbiter that shares one 2-to-4 decoded select bus between four requesters.
- Drives the decoder-style interface: 2-bit index W, enable En, one-hot outputs y0..y3.
- A grant is held while its request stays high, up to MAX_HOLD cycles.
- One dead cycle separates consecutive grants, so two selects are never active back-to-back.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one grant may last. Legal range is 2 or more.
- Hold counter width is $clog2(MAX_HOLD+1).

Ports:
- clk      input   1  rising-edge clock
- rst      input   1  synchronous, active-high reset
- req      input   4  request vector; req[i] belongs to requester i
- W        output  2  granted index (registered)
- En       output  1  grant valid (registered)
- y0       output  1  grant to requester 0, equal to En && W==0
- y1       output  1  grant to requester 1, equal to En && W==1
- y2       output  1  grant to requester 2, equal to En && W==2
- y3       output  1  grant to requester 3, equal to En && W==3
- timeout  output  1  one-cycle pulse when a grant is force-released

Behaviour:
- All outputs are registered. Nothing is combinational from req to any output.
- Reset, sampled at a clk edge with rst=1:
  - state=IDLE, W=0, En=0, y0..y3=0, timeout=0, hold_cnt=0.
  - Priority pointer ptr=3, so requester 0 has top priority after reset.
  - Reset mid-grant drops En and all y at that same edge.
- States: IDLE, GRANT, GAP.
- IDLE and GAP, arbitration at each edge:
  - If req!=0, pick the first set bit scanning (ptr+1), (ptr+2), (ptr+3), ptr, all mod 4.
  - At that edge: W=idx, En=1, y[idx]=1, ptr=idx, hold_cnt=1, go to GRANT.
  - If req==0, stay in or go to IDLE with outputs low.
  - GAP lasts exactly one cycle.
- Latency: req sampled at edge k gives the grant visible after edge k.
- GRANT, evaluated at each edge:
  - If req[W]==0: release. En=0, all y=0, go to GAP, timeout=0.
  - Else if hold_cnt==MAX_HOLD: forced release. En=0, all y=0, timeout=1 for one cycle, go to GAP.
  - Else: hold_cnt+1, outputs unchanged.
  - The release check takes priority over the timeout check when both apply.
- A grant therefore lasts between 1 and MAX_HOLD cycles. The cycle after any release always has all y low.
- W holds the last granted index while En=0. W returns to 0 only on reset.
- Requests from other requesters during GRANT are ignored; they are arbitrated in GAP.
- A force-released requester becomes lowest priority through ptr. It is regranted after the gap only if no other req bit is set.
- Invariants, checked by assertion:
  - At most one of y0..y3 is high.
  - y0..y3 are all low whenever En=0.
  - timeout is never high in two consecutive cycles.
- req is synchronous to clk. There are no X-handling requirements beyond reset.

Test Plan:
- Reset, then req=0001 at edge 1 -> after edge 1: W=0, En=1, y0=1. req=0000 sampled at edge 4 -> after edge 4: En=0, y=0000, timeout=0.
- req=1111 held, MAX_HOLD=8 -> grants in order 0,1,2,3,0. Each grant lasts 8 cycles, one gap cycle between grants, and timeout pulses once per grant.
- req=0101 -> grant 0. Drop req[0] for one cycle then reassert it -> next grant is 2, not 0.
- req=0100 held continuously -> y2 high 8 cycles, timeout=1, 1 gap cycle, then y2 high again.
- rst=1 during a grant of 2 -> after that edge En=0, W=0, y=0000. Then req=1001 -> grant 0 first (ptr=3), then 3.
- req=0010 for a single cycle -> y1 high for exactly 1 cycle, then gap. No timeout.
